// File: rtl/occupancy_ctrl_if.sv
// Bundles the gate sensor inputs and the counter-side outputs of occupancy_ctrl.
// master drives the sensors (environment side); slave is the controller itself.
interface occupancy_ctrl_if #(
  parameter int WIDTH = 5
);
  logic             a;
  logic             b;
  logic             increase;
  logic             decrease;
  logic             reject;
  logic [WIDTH-1:0] count;
  logic             full;
  logic             empty;

  modport master (
    output a, b,
    input  increase, decrease, reject, count, full, empty
  );

  modport slave (
    input  a, b,
    output increase, decrease, reject, count, full, empty
  );
endinterface

// File: rtl/occupancy_ctrl.sv
// Gate-sensor sequencer that validates enter/exit events and owns the occupancy count.
// Optional OCCUPANCY_CTRL_SYNC_EN adds a two-flop synchronizer on A and B (+2 cycles latency).
module occupancy_ctrl #(
  parameter int WIDTH = 5,
  parameter int MAX   = 25
) (
  input  logic             clk,
  input  logic             rst,
  occupancy_ctrl_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE,
    E1,
    E2,
    E3,
    X1,
    X2,
    X3,
    WAIT
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [1:0]       ab;
  logic             enter_evt;
  logic             exit_evt;
  logic [WIDTH-1:0] count_q;
  logic             increase_q;
  logic             decrease_q;
  logic             reject_q;

`ifdef OCCUPANCY_CTRL_SYNC_EN
  logic [1:0] sync_a;
  logic [1:0] sync_b;

  // Sensors are asynchronous to clk when this build is used.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= 2'b00;
      sync_b <= 2'b00;
    end else begin
      sync_a <= {sync_a[0], bus.a};
      sync_b <= {sync_b[0], bus.b};
    end
  end

  assign ab = {sync_a[1], sync_b[1]};
`else
  assign ab = {bus.a, bus.b};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    enter_evt  = 1'b0;
    exit_evt   = 1'b0;
    unique case (state)
      IDLE: begin
        unique case (ab)
          2'b10:   state_next = E1;
          2'b01:   state_next = X1;
          2'b11:   state_next = WAIT;
          default: state_next = IDLE;
        endcase
      end
      E1: begin
        unique case (ab)
          2'b11:   state_next = E2;
          2'b10:   state_next = E1;
          2'b01:   state_next = WAIT;
          default: state_next = IDLE;
        endcase
      end
      E2: begin
        unique case (ab)
          2'b01:   state_next = E3;
          2'b10:   state_next = E1;
          2'b11:   state_next = E2;
          default: state_next = IDLE;
        endcase
      end
      E3: begin
        unique case (ab)
          2'b11:   state_next = E2;
          2'b01:   state_next = E3;
          2'b10:   state_next = WAIT;
          default: begin
            state_next = IDLE;
            enter_evt  = 1'b1;
          end
        endcase
      end
      X1: begin
        unique case (ab)
          2'b11:   state_next = X2;
          2'b01:   state_next = X1;
          2'b10:   state_next = WAIT;
          default: state_next = IDLE;
        endcase
      end
      X2: begin
        unique case (ab)
          2'b10:   state_next = X3;
          2'b01:   state_next = X1;
          2'b11:   state_next = X2;
          default: state_next = IDLE;
        endcase
      end
      X3: begin
        unique case (ab)
          2'b11:   state_next = X2;
          2'b10:   state_next = X3;
          2'b01:   state_next = WAIT;
          default: begin
            state_next = IDLE;
            exit_evt   = 1'b1;
          end
        endcase
      end
      default: begin
        if (ab == 2'b00) begin
          state_next = IDLE;
        end
      end
    endcase
  end

  // Count and strobes move on the same edge that sees the terminating 00.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      increase_q <= 1'b0;
      decrease_q <= 1'b0;
      reject_q   <= 1'b0;
    end else begin
      increase_q <= 1'b0;
      decrease_q <= 1'b0;
      reject_q   <= 1'b0;
      if (enter_evt) begin
        if (count_q < MAX_C) begin
          count_q    <= count_q + ONE_C;
          increase_q <= 1'b1;
        end else begin
          reject_q   <= 1'b1;
        end
      end else if (exit_evt) begin
        if (count_q != '0) begin
          count_q    <= count_q - ONE_C;
          decrease_q <= 1'b1;
        end else begin
          reject_q   <= 1'b1;
        end
      end
    end
  end

  assign bus.count    = count_q;
  assign bus.increase = increase_q;
  assign bus.decrease = decrease_q;
  assign bus.reject   = reject_q;
  assign bus.full     = (count_q == MAX_C);
  assign bus.empty    = (count_q == '0);

endmodule
